input_conditioner: RTL and testbench

Upstream stage for the control FSMs. It turns raw asynchronous board buttons and a switch field into the clean, single-clock-domain inputs an FSM consumes.
- Each button is synchronized and debounced, and produces a stable level plus a one-cycle press pulse.
- The switch field is synchronized and debounced as a group, and produces a stable value plus a one-cycle change pulse.

---
 rtl/conditioner_pkg.sv | 7 +
 rtl/debounce_one_shot.sv | 77 +++++++
 rtl/input_conditioner.sv | 55 +++++
 tb/tb_input_conditioner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/conditioner_pkg.sv
// conditioner_pkg: shared button FSM states and counter sizing for the input conditioner
package conditioner_pkg;
  typedef enum logic [1:0] {ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW} DB_STATES;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debounce_one_shot.sv
// debounce_one_shot: one button channel, 2-flop sync plus debounce FSM with press pulse
module debounce_one_shot
  import conditioner_pkg::*;
#(
  parameter int DB_COUNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int DB_CNT_W = cnt_w(DB_COUNT);
  localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DB_COUNT - 1);
  logic [1:0] sync;
  logic s;
  DB_STATES state, state_n;
  logic [DB_CNT_W-1:0] cnt, cnt_n;
  logic level_n, pulse_n;
  assign s = sync[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      pulse <= pulse_n;
    end
  end
  // any disagreement with the current qualification direction restarts from zero
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    pulse_n = 1'b0;
    case (state)
      ST_LOW: begin
        if (s) begin
          state_n = ST_WAIT_HIGH;
          cnt_n   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s) begin
          state_n = ST_LOW;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = ST_HIGH;
          level_n = 1'b1;
          pulse_n = 1'b1;
        end else
          cnt_n = cnt + 1'b1;
      end
      ST_HIGH: begin
        if (!s) begin
          state_n = ST_WAIT_LOW;
          cnt_n   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (s)
          state_n = ST_HIGH;
        else if (cnt == LAST) begin
          state_n = ST_LOW;
          level_n = 1'b0;
        end else
          cnt_n = cnt + 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces buttons (level + press pulse) and a switch group
module input_conditioner
  import conditioner_pkg::*;
#(
  parameter int NBTN     = 2,
  parameter int SW_W     = 4,
  parameter int DB_COUNT = 500000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] BTN_IN,
  input  logic [SW_W-1:0] SW_IN,
  output logic [NBTN-1:0] BTN_LEVEL,
  output logic [NBTN-1:0] BTN_PULSE,
  output logic [SW_W-1:0] SW_OUT,
  output logic            SW_CHG
);
  localparam int DB_CNT_W = cnt_w(DB_COUNT);
  localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DB_COUNT - 1);
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce_one_shot #(.DB_COUNT(DB_COUNT)) u_db (
      .clk  (CLK),
      .rst  (RST),
      .raw  (BTN_IN[i]),
      .level(BTN_LEVEL[i]),
      .pulse(BTN_PULSE[i])
    );
  end
  logic [SW_W-1:0] sw_s1, sw_s2, cand;
  logic [DB_CNT_W-1:0] scnt;
  // the whole field must hold one value, so staggered bit arrivals yield a single update
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      cand   <= '0;
      scnt   <= '0;
      SW_OUT <= '0;
      SW_CHG <= 1'b0;
    end else begin
      sw_s1  <= SW_IN;
      sw_s2  <= sw_s1;
      SW_CHG <= 1'b0;
      if (sw_s2 != cand) begin
        cand <= sw_s2;
        scnt <= '0;
      end else if (scnt == LAST && cand != SW_OUT) begin
        SW_OUT <= cand;
        SW_CHG <= 1'b1;
        scnt   <= '0;
      end else if (scnt != LAST)
        scnt <= scnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed stimulus checked against a run-length reference model
module tb_input_conditioner;
  localparam int NBTN = 2;
  localparam int SW_W = 4;
  localparam int DB = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [NBTN-1:0] BTN_IN = '0;
  logic [SW_W-1:0] SW_IN = '0;
  logic [NBTN-1:0] BTN_LEVEL, BTN_PULSE;
  logic [SW_W-1:0] SW_OUT;
  logic SW_CHG;
  typedef struct packed {
    logic [NBTN-1:0] lvl;
    logic [NBTN-1:0] pls;
    logic [SW_W-1:0] sw;
    logic            chg;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int p0_cnt = 0;
  int chg_cnt = 0;
  logic [NBTN-1:0] m_b1, m_b2, m_lvl, m_pls;
  int m_run[NBTN];
  logic [SW_W-1:0] m_s1, m_s2, m_prev, m_swo;
  int m_r;
  logic m_chg;
  always #5 CLK = ~CLK;
  input_conditioner #(.NBTN(NBTN), .SW_W(SW_W), .DB_COUNT(DB)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_IN   (BTN_IN),
    .SW_IN    (SW_IN),
    .BTN_LEVEL(BTN_LEVEL),
    .BTN_PULSE(BTN_PULSE),
    .SW_OUT   (SW_OUT),
    .SW_CHG   (SW_CHG)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  // An output flips once the synchronized input has disagreed with it for DB+1 consecutive edges;
  // the switch field updates once one synchronized value has been seen for DB+1 consecutive edges.
  task automatic step(input logic rst, input logic [NBTN-1:0] b, input logic [SW_W-1:0] w);
    logic [NBTN-1:0] s;
    logic [SW_W-1:0] sv;
    exp_t e;
    @(negedge CLK);
    RST = rst;
    BTN_IN = b;
    SW_IN = w;
    if (rst) begin
      m_b1 = '0; m_b2 = '0; m_lvl = '0; m_pls = '0;
      for (int i = 0; i < NBTN; i++) m_run[i] = 0;
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_swo = '0; m_r = 1; m_chg = 1'b0;
    end else begin
      s = m_b2; m_b2 = m_b1; m_b1 = b; m_pls = '0;
      for (int i = 0; i < NBTN; i++) begin
        m_run[i] = (s[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == DB + 1) begin
          m_lvl[i] = s[i];
          m_pls[i] = s[i];
          m_run[i] = 0;
        end
      end
      sv = m_s2; m_s2 = m_s1; m_s1 = w; m_chg = 1'b0;
      if (sv != m_prev) begin
        m_prev = sv;
        m_r = 1;
      end else if (m_r < DB + 1) m_r++;
      if (m_r == DB + 1 && sv != m_swo) begin
        m_swo = sv;
        m_chg = 1'b1;
      end
    end
    e.lvl = m_lvl; e.pls = m_pls; e.sw = m_swo; e.chg = m_chg;
    q.push_back(e);
  endtask
  task automatic hold(input int n, input logic [NBTN-1:0] b, input logic [SW_W-1:0] w);
    for (int k = 0; k < n; k++) step(1'b0, b, w);
  endtask
  task automatic settle();
    @(posedge CLK);
    #2;
  endtask
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("btn_level", 32'(BTN_LEVEL), 32'(e.lvl));
      chk("btn_pulse", 32'(BTN_PULSE), 32'(e.pls));
      chk("sw_out", 32'(SW_OUT), 32'(e.sw));
      chk("sw_chg", 32'(SW_CHG), 32'(e.chg));
      if (BTN_PULSE[0]) p0_cnt++;
      if (SW_CHG) chg_cnt++;
    end
  end
  initial begin
    logic [NBTN-1:0] b;
    logic [SW_W-1:0] w;
    for (int k = 0; k < 3; k++) step(1'b1, '0, '0);
    hold(4, 2'b00, 4'h0);
    p0_cnt = 0;
    hold(12, 2'b01, 4'h0);
    settle();
    chk("press_pulse_count", p0_cnt, 1);
    p0_cnt = 0;
    hold(3, 2'b00, 4'h0);
    hold(2, 2'b01, 4'h0);
    hold(12, 2'b00, 4'h0);
    settle();
    chk("release_pulse_count", p0_cnt, 0);
    chk("release_level", 32'(BTN_LEVEL), 0);
    p0_cnt = 0;
    hold(3, 2'b01, 4'h0);
    hold(1, 2'b00, 4'h0);
    hold(12, 2'b01, 4'h0);
    settle();
    chk("bounce_pulse_count", p0_cnt, 1);
    hold(10, 2'b00, 4'h0);
    chg_cnt = 0;
    hold(2, 2'b00, 4'h1);
    hold(10, 2'b00, 4'h5);
    settle();
    chk("sw_change_count", chg_cnt, 1);
    chk("sw_value", 32'(SW_OUT), 32'h5);
    chg_cnt = 0;
    hold(10, 2'b00, 4'h5);
    settle();
    chk("sw_hold_count", chg_cnt, 0);
    p0_cnt = 0;
    hold(4, 2'b01, 4'h5);
    step(1'b1, 2'b01, 4'h5);
    settle();
    chk("reset_outputs", {BTN_LEVEL, BTN_PULSE, SW_OUT, SW_CHG}, 0);
    chk("reset_no_pulse", p0_cnt, 0);
    hold(10, 2'b01, 4'h0);
    settle();
    chk("post_reset_pulse_count", p0_cnt, 1);
    hold(8, 2'b00, 4'h0);
    hold(12, 2'b11, 4'h0);
    hold(10, 2'b00, 4'h0);
    b = '0;
    w = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NBTN; i++)
        if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 11) == 0) w = SW_W'($urandom);
      else if ($urandom_range(0, 7) == 0) w[$urandom_range(0, SW_W - 1)] ^= 1'b1;
      step($urandom_range(0, 399) == 0, b, w);
    end
    hold(12, b, w);
    settle();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
